// File: rtl/imu_read_sequencer_pkg.sv
// Shared register map, burst geometry and state encoding for the IMU read sequencer.
package imu_read_sequencer_pkg;

    localparam logic [7:0] REG_OPR_MODE = 8'h3D;
    localparam logic [7:0] REG_ACC_DATA = 8'h08;
    localparam logic [7:0] REG_GYR_DATA = 8'h14;
    localparam logic [7:0] MODE_NDOF    = 8'h0C;
    localparam int         BURST_LEN    = 6;

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG_REQ,
        CFG_WAIT,
        IDLE,
        ACC_REQ,
        ACC_WAIT,
        GYR_REQ,
        GYR_WAIT,
        PUBLISH,
        FAULT
    } state_t;

endpackage

// File: rtl/imu_axis_unpack.sv
// Six-byte burst collector: stores (LSB, MSB) pairs for x, y, z in arrival order
// and flags when a full burst has been seen, counting a byte arriving this cycle.
module imu_axis_unpack
    import imu_read_sequencer_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic signed [15:0] word_x,
    output logic signed [15:0] word_y,
    output logic signed [15:0] word_z,
    output logic               complete
);

    logic [7:0] bytes_q [BURST_LEN];
    logic [2:0] idx;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idx <= '0;
            for (int i = 0; i < BURST_LEN; i++) bytes_q[i] <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (byte_valid && idx < 3'(BURST_LEN)) begin
            bytes_q[idx] <= byte_in;
            idx          <= idx + 1'b1;
        end
    end

    assign word_x   = {bytes_q[1], bytes_q[0]};
    assign word_y   = {bytes_q[3], bytes_q[2]};
    assign word_z   = {bytes_q[5], bytes_q[4]};
    assign complete = (idx == 3'(BURST_LEN)) || (idx == 3'(BURST_LEN - 1) && byte_valid);

endmodule

// File: rtl/imu_read_sequencer.sv
// IMU register sequencer: power-up wait, mode write, then periodic accel/gyro
// burst reads through a byte-level I2C master, with retry and sticky fault.
//
// state     | meaning
// INIT_WAIT | sensor power-up delay after reset
// CFG_REQ   | requesting operating-mode write
// CFG_WAIT  | mode write in flight
// IDLE      | waiting for a pending poll tick
// ACC_REQ   | requesting accelerometer burst
// ACC_WAIT  | accelerometer bytes arriving
// GYR_REQ   | requesting gyroscope burst
// GYR_WAIT  | gyroscope bytes arriving
// PUBLISH   | copy shadow sample to outputs
// FAULT     | retries exhausted, parked until reset
module imu_read_sequencer
    import imu_read_sequencer_pkg::*;
#(
    parameter int N_ROTATION       = 36,
    parameter int N_ACCEL          = 36,
    parameter int INIT_WAIT_CYCLES = 25000000,
    parameter int POLL_CYCLES      = 380000,
    parameter int MAX_RETRY        = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  i2c_req,
    input  logic                  i2c_ack,
    output logic                  i2c_rw,
    output logic [7:0]            i2c_reg,
    output logic [3:0]            i2c_len,
    output logic [7:0]            i2c_wdata,
    input  logic                  i2c_rd_valid,
    input  logic [7:0]            i2c_rd_byte,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic [N_ACCEL-1:0]    x_accel,
    output logic [N_ACCEL-1:0]    y_accel,
    output logic [N_ACCEL-1:0]    z_accel,
    output logic [N_ROTATION-1:0] x_rotation,
    output logic [N_ROTATION-1:0] y_rotation,
    output logic [N_ROTATION-1:0] z_rotation,
    output logic                  sample_valid,
    output logic                  init_done,
    output logic                  overrun,
    output logic                  fault
);

    localparam int INIT_W  = $clog2(INIT_WAIT_CYCLES + 1);
    localparam int POLL_W  = $clog2(POLL_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    state_t             state;
    logic [INIT_W-1:0]  init_cnt;
    logic [POLL_W-1:0]  poll_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               pending;
    logic [15:0]        acc_x, acc_y, acc_z;

    logic signed [15:0] word_x, word_y, word_z;
    logic               complete;
    logic               poll_run, tick, consume, byte_valid, unpack_clear;
    logic               xfer_ok, retry_exhausted;

    assign poll_run        = init_done && enable;
    assign tick            = poll_run && (poll_cnt == POLL_W'(POLL_CYCLES - 1));
    assign consume         = (state == IDLE) && pending;
    assign byte_valid      = i2c_rd_valid && (state == ACC_WAIT || state == GYR_WAIT);
    assign unpack_clear    = (state == ACC_REQ) || (state == GYR_REQ);
    assign xfer_ok         = !i2c_nack && (state == CFG_WAIT || complete);
    assign retry_exhausted = (retry_cnt == RETRY_W'(MAX_RETRY));

    imu_axis_unpack u_unpack (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .clear      (unpack_clear),
        .byte_valid (byte_valid),
        .byte_in    (i2c_rd_byte),
        .word_x     (word_x),
        .word_y     (word_y),
        .word_z     (word_z),
        .complete   (complete)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= INIT_WAIT;
            init_cnt     <= '0;
            poll_cnt     <= '0;
            retry_cnt    <= '0;
            pending      <= 1'b0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            i2c_req      <= 1'b0;
            i2c_rw       <= 1'b0;
            i2c_reg      <= '0;
            i2c_len      <= '0;
            i2c_wdata    <= '0;
            x_accel      <= '0;
            y_accel      <= '0;
            z_accel      <= '0;
            x_rotation   <= '0;
            y_rotation   <= '0;
            z_rotation   <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            overrun      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;

            // A tick landing while the previous one is still unconsumed is lost.
            if (!poll_run) begin
                poll_cnt <= '0;
                pending  <= 1'b0;
            end else begin
                poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
                if (tick) begin
                    if (pending && !consume) overrun <= 1'b1;
                    pending <= 1'b1;
                end else if (consume) begin
                    pending <= 1'b0;
                end
            end

            case (state)
                INIT_WAIT: begin
                    if (init_cnt == INIT_W'(INIT_WAIT_CYCLES - 1)) state <= CFG_REQ;
                    else init_cnt <= init_cnt + 1'b1;
                end
                CFG_REQ: begin
                    i2c_rw    <= 1'b0;
                    i2c_reg   <= REG_OPR_MODE;
                    i2c_len   <= 4'd1;
                    i2c_wdata <= MODE_NDOF;
                    if (i2c_req && i2c_ack) begin
                        i2c_req <= 1'b0;
                        state   <= CFG_WAIT;
                    end else i2c_req <= 1'b1;
                end
                CFG_WAIT: if (i2c_done) begin
                    if (xfer_ok) begin
                        retry_cnt <= '0;
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else if (retry_exhausted) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= CFG_REQ;
                    end
                end
                IDLE: if (pending) state <= ACC_REQ;
                ACC_REQ: begin
                    i2c_rw  <= 1'b1;
                    i2c_reg <= REG_ACC_DATA;
                    i2c_len <= 4'(BURST_LEN);
                    if (i2c_req && i2c_ack) begin
                        i2c_req <= 1'b0;
                        state   <= ACC_WAIT;
                    end else i2c_req <= 1'b1;
                end
                ACC_WAIT: if (i2c_done) begin
                    if (xfer_ok) begin
                        retry_cnt <= '0;
                        state     <= GYR_REQ;
                    end else if (retry_exhausted) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ACC_REQ;
                    end
                end
                GYR_REQ: begin
                    // Collector still holds accel bytes only on the first gyro attempt.
                    if (retry_cnt == '0) begin
                        acc_x <= word_x;
                        acc_y <= word_y;
                        acc_z <= word_z;
                    end
                    i2c_rw  <= 1'b1;
                    i2c_reg <= REG_GYR_DATA;
                    i2c_len <= 4'(BURST_LEN);
                    if (i2c_req && i2c_ack) begin
                        i2c_req <= 1'b0;
                        state   <= GYR_WAIT;
                    end else i2c_req <= 1'b1;
                end
                GYR_WAIT: if (i2c_done) begin
                    if (xfer_ok) begin
                        retry_cnt <= '0;
                        state     <= PUBLISH;
                    end else if (retry_exhausted) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= GYR_REQ;
                    end
                end
                PUBLISH: begin
                    x_accel      <= {{(N_ACCEL-16){acc_x[15]}}, acc_x};
                    y_accel      <= {{(N_ACCEL-16){acc_y[15]}}, acc_y};
                    z_accel      <= {{(N_ACCEL-16){acc_z[15]}}, acc_z};
                    x_rotation   <= {{(N_ROTATION-16){word_x[15]}}, word_x};
                    y_rotation   <= {{(N_ROTATION-16){word_y[15]}}, word_y};
                    z_rotation   <= {{(N_ROTATION-16){word_z[15]}}, word_z};
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                FAULT: begin
                    fault   <= 1'b1;
                    i2c_req <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_read_sequencer.sv
// Directed bench for imu_read_sequencer: a scripted I2C master serves each
// transaction and every scenario task compares against hand-derived values.
module tb_imu_read_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        i2c_req, i2c_rw;
    logic        i2c_ack = 1'b0;
    logic [7:0]  i2c_reg, i2c_wdata;
    logic [3:0]  i2c_len;
    logic        i2c_rd_valid = 1'b0;
    logic [7:0]  i2c_rd_byte = 8'h00;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic [35:0] x_accel, y_accel, z_accel, x_rotation, y_rotation, z_rotation;
    logic        sample_valid, init_done, overrun, fault;
    logic [215:0] outs;

    int checks = 0;
    int failures = 0;
    int sv_cnt = 0;
    int ov_cnt = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    localparam logic [215:0] EXP1 = {36'h0_0000_1234, 36'hF_FFFF_8000, 36'h0_0000_7FFF,
                                     36'h0_0000_0001, 36'hF_FFFF_FFFE, 36'h0_0000_0000};
    localparam logic [215:0] EXP2 = {36'h0_0000_0005, 36'hF_FFFF_FFFF, 36'h0_0000_0100,
                                     36'hF_FFFF_8001, 36'h0_0000_0010, 36'h0_0000_7000};
    localparam logic [215:0] EXP3 = {36'h0_0000_1111, 36'h0_0000_2222, 36'hF_FFFF_C000,
                                     36'h0_0000_0003, 36'h0_0000_0004, 36'hF_FFFF_FFFB};
    localparam logic [47:0] ACC1 = 48'h7FFF_8000_1234, GYR1 = 48'h0000_FFFE_0001;
    localparam logic [47:0] ACC2 = 48'h0100_FFFF_0005, GYR2 = 48'h7000_0010_8001;
    localparam logic [47:0] ACC3 = 48'hC000_2222_1111, GYR3 = 48'hFFFB_0004_0003;

    assign outs = {x_accel, y_accel, z_accel, x_rotation, y_rotation, z_rotation};

    imu_read_sequencer #(
        .N_ROTATION(36), .N_ACCEL(36), .INIT_WAIT_CYCLES(10), .POLL_CYCLES(100), .MAX_RETRY(2)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .enable(enable),
        .i2c_req(i2c_req), .i2c_ack(i2c_ack), .i2c_rw(i2c_rw), .i2c_reg(i2c_reg),
        .i2c_len(i2c_len), .i2c_wdata(i2c_wdata), .i2c_rd_valid(i2c_rd_valid),
        .i2c_rd_byte(i2c_rd_byte), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .x_accel(x_accel), .y_accel(y_accel), .z_accel(z_accel),
        .x_rotation(x_rotation), .y_rotation(y_rotation), .z_rotation(z_rotation),
        .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun), .fault(fault)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (i2c_req && !req_prev) req_rises++;
        req_prev = i2c_req;
        if (sample_valid) sv_cnt++;
        if (overrun) ov_cnt++;
    end

    // Scripted master: wait for a request, check the command, ack, stream bytes, finish.
    task automatic serve(input string name, input logic rw, input logic [7:0] reg_a,
                         input logic [3:0] len, input logic [7:0] wdata, input logic [47:0] data,
                         input int nbytes, input logic nack, input int delay,
                         input logic done_with_last);
        int waited = 0;
        while (!i2c_req && waited < 400) begin
            @(posedge sys_clk); #1;
            waited++;
        end
        checks++;
        if (i2c_req !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_timeout: i2c_req=%b after %0d cycles, required 1", name, i2c_req, waited);
            return;
        end
        checks++;
        if (i2c_rw !== rw || i2c_reg !== reg_a || i2c_len !== len || (!rw && i2c_wdata !== wdata)) begin
            failures++;
            $display("FAIL %s_cmd: rw=%b reg=%h len=%0d wdata=%h, required rw=%b reg=%h len=%0d wdata=%h",
                     name, i2c_rw, i2c_reg, i2c_len, i2c_wdata, rw, reg_a, len, wdata);
        end
        i2c_ack = 1'b1;
        @(posedge sys_clk); #1;
        i2c_ack = 1'b0;
        checks++;
        if (i2c_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_req_drop: i2c_req=%b after ack, required 0", name, i2c_req);
        end
        repeat (delay) begin @(posedge sys_clk); #1; end
        for (int i = 0; i < nbytes; i++) begin
            i2c_rd_valid = 1'b1;
            i2c_rd_byte  = data[8*i +: 8];
            i2c_done     = done_with_last && (i == nbytes - 1);
            i2c_nack     = nack && i2c_done;
            @(posedge sys_clk); #1;
        end
        i2c_rd_valid = 1'b0;
        if (!(done_with_last && nbytes > 0)) begin
            i2c_done = 1'b1;
            i2c_nack = nack;
            @(posedge sys_clk); #1;
        end
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge sys_clk); #1;
        checks++;
        if ({i2c_req, i2c_rw, i2c_reg, i2c_len, i2c_wdata, sample_valid, init_done, overrun, fault} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b rw=%b reg=%h len=%0d init_done=%b fault=%b, required all 0",
                     i2c_req, i2c_rw, i2c_reg, i2c_len, init_done, fault);
        end
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outs: outs=%h, required 0", outs);
        end
        rst = 1'b0;
        repeat (10) @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b0) begin
            failures++;
            $display("FAIL cfg_req_early: i2c_req=%b at cycle 10, required 0", i2c_req);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b1) begin
            failures++;
            $display("FAIL cfg_req_cycle11: i2c_req=%b at cycle 11, required 1", i2c_req);
        end
        serve("cfg", 1'b0, 8'h3D, 4'd1, 8'h0C, 48'h0, 0, 1'b0, 0, 1'b0);
        checks++;
        if (init_done !== 1'b1 || outs !== '0) begin
            failures++;
            $display("FAIL init_done: init_done=%b outs=%h, required 1 and 0", init_done, outs);
        end
    endtask

    task automatic test_sample();
        int sv0 = sv_cnt;
        repeat (101) @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b0) begin
            failures++;
            $display("FAIL tick_latency_early: i2c_req=%b, required 0", i2c_req);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b1) begin
            failures++;
            $display("FAIL tick_latency: i2c_req=%b, required 1", i2c_req);
        end
        serve("acc1", 1'b1, 8'h08, 4'd6, 8'h00, ACC1, 6, 1'b0, 0, 1'b1);
        serve("gyr1", 1'b1, 8'h14, 4'd6, 8'h00, GYR1, 6, 1'b0, 0, 1'b1);
        checks++;
        if (sample_valid !== 1'b0 || outs !== '0) begin
            failures++;
            $display("FAIL publish_early: sample_valid=%b outs=%h, required 0 and 0", sample_valid, outs);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (sample_valid !== 1'b1 || outs !== EXP1) begin
            failures++;
            $display("FAIL sample1: sample_valid=%b outs=%h, required 1 and %h", sample_valid, outs, EXP1);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (sample_valid !== 1'b0 || sv_cnt != sv0 + 1) begin
            failures++;
            $display("FAIL sample1_pulse: sample_valid=%b count=%0d, required 0 and %0d", sample_valid, sv_cnt - sv0, 1);
        end
    endtask

    task automatic test_retry();
        int sv0 = sv_cnt;
        int r0 = req_rises;
        serve("acc_nack1", 1'b1, 8'h08, 4'd6, 8'h00, 48'h0, 0, 1'b1, 0, 1'b0);
        serve("acc_nack2", 1'b1, 8'h08, 4'd6, 8'h00, 48'hFFFF_FFFF_FFFF, 6, 1'b1, 0, 1'b0);
        checks++;
        if (outs !== EXP1 || sv_cnt != sv0) begin
            failures++;
            $display("FAIL retry_hold: outs=%h samples=%0d, required %h and 0", outs, sv_cnt - sv0, EXP1);
        end
        serve("acc_ok", 1'b1, 8'h08, 4'd6, 8'h00, ACC2, 6, 1'b0, 0, 1'b0);
        serve("gyr_ok", 1'b1, 8'h14, 4'd6, 8'h00, GYR2, 6, 1'b0, 0, 1'b0);
        repeat (2) @(posedge sys_clk); #1;
        checks++;
        if (outs !== EXP2 || sv_cnt != sv0 + 1 || req_rises != r0 + 4) begin
            failures++;
            $display("FAIL retry_sample: outs=%h samples=%0d requests=%0d, required %h, 1, 4",
                     outs, sv_cnt - sv0, req_rises - r0, EXP2);
        end
    endtask

    task automatic test_short_gyro();
        int sv0 = sv_cnt;
        serve("acc3", 1'b1, 8'h08, 4'd6, 8'h00, ACC3, 6, 1'b0, 0, 1'b0);
        serve("gyr_short", 1'b1, 8'h14, 4'd6, 8'h00, 48'hDEAD_BEEF_CAFE, 4, 1'b0, 0, 1'b0);
        repeat (2) @(posedge sys_clk); #1;
        checks++;
        if (outs !== EXP2 || sv_cnt != sv0) begin
            failures++;
            $display("FAIL short_hold: outs=%h samples=%0d, required %h and 0", outs, sv_cnt - sv0, EXP2);
        end
        serve("gyr_retry", 1'b1, 8'h14, 4'd6, 8'h00, GYR3, 6, 1'b0, 0, 1'b0);
        repeat (2) @(posedge sys_clk); #1;
        checks++;
        if (outs !== EXP3 || sv_cnt != sv0 + 1) begin
            failures++;
            $display("FAIL short_retry: outs=%h samples=%0d, required %h and 1", outs, sv_cnt - sv0, EXP3);
        end
    endtask

    task automatic test_overrun();
        int sv0 = sv_cnt;
        int ov0 = ov_cnt;
        int r0;
        int waited = 0;
        serve("acc_slow", 1'b1, 8'h08, 4'd6, 8'h00, ACC1, 6, 1'b0, 250, 1'b0);
        serve("gyr_slow", 1'b1, 8'h14, 4'd6, 8'h00, GYR1, 6, 1'b0, 0, 1'b0);
        checks++;
        if (ov_cnt != ov0 + 1) begin
            failures++;
            $display("FAIL overrun_count: overrun pulses=%0d, required 1", ov_cnt - ov0);
        end
        while (!i2c_req && waited < 10) begin
            @(posedge sys_clk); #1;
            waited++;
        end
        checks++;
        if (i2c_req !== 1'b1 || outs !== EXP1) begin
            failures++;
            $display("FAIL extra_start: i2c_req=%b outs=%h, required 1 and %h", i2c_req, outs, EXP1);
        end
        enable = 1'b0;
        serve("acc_extra", 1'b1, 8'h08, 4'd6, 8'h00, ACC2, 6, 1'b0, 0, 1'b0);
        serve("gyr_extra", 1'b1, 8'h14, 4'd6, 8'h00, GYR2, 6, 1'b0, 0, 1'b0);
        repeat (2) @(posedge sys_clk); #1;
        r0 = req_rises;
        checks++;
        if (outs !== EXP2 || sv_cnt != sv0 + 2) begin
            failures++;
            $display("FAIL extra_sample: outs=%h samples=%0d, required %h and 2", outs, sv_cnt - sv0, EXP2);
        end
        repeat (300) @(posedge sys_clk); #1;
        checks++;
        if (req_rises != r0 || ov_cnt != ov0 + 1 || sv_cnt != sv0 + 2) begin
            failures++;
            $display("FAIL disabled_quiet: requests=%0d overruns=%0d samples=%0d, required 0, 1, 2",
                     req_rises - r0, ov_cnt - ov0, sv_cnt - sv0);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        enable = 1'b1;
        while (!i2c_req && waited < 200) begin
            @(posedge sys_clk); #1;
            waited++;
        end
        checks++;
        if (i2c_req !== 1'b1) begin
            failures++;
            $display("FAIL midrst_req: i2c_req=%b, required 1", i2c_req);
        end
        i2c_ack = 1'b1;
        @(posedge sys_clk); #1;
        i2c_ack = 1'b0;
        i2c_rd_valid = 1'b1;
        i2c_rd_byte = 8'h55;
        repeat (2) @(posedge sys_clk); #1;
        i2c_rd_valid = 1'b0;
        rst = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b0 || outs !== '0 || init_done !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: req=%b init_done=%b fault=%b outs=%h, required all 0",
                     i2c_req, init_done, fault, outs);
        end
        rst = 1'b0;
        repeat (10) @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b0) begin
            failures++;
            $display("FAIL reinit_early: i2c_req=%b at cycle 10, required 0", i2c_req);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (i2c_req !== 1'b1) begin
            failures++;
            $display("FAIL reinit_cycle11: i2c_req=%b at cycle 11, required 1", i2c_req);
        end
        serve("recfg", 1'b0, 8'h3D, 4'd1, 8'h0C, 48'h0, 0, 1'b0, 0, 1'b0);
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL reinit_done: init_done=%b, required 1", init_done);
        end
    endtask

    task automatic test_fault();
        int sv0;
        int r0;
        serve("acc_pre", 1'b1, 8'h08, 4'd6, 8'h00, ACC1, 6, 1'b0, 0, 1'b0);
        serve("gyr_pre", 1'b1, 8'h14, 4'd6, 8'h00, GYR1, 6, 1'b0, 0, 1'b0);
        repeat (2) @(posedge sys_clk); #1;
        checks++;
        if (outs !== EXP1) begin
            failures++;
            $display("FAIL prefault_sample: outs=%h, required %h", outs, EXP1);
        end
        sv0 = sv_cnt;
        for (int k = 0; k < 3; k++)
            serve("acc_fail", 1'b1, 8'h08, 4'd6, 8'h00, 48'h0, 6, 1'b1, 0, 1'b0);
        checks++;
        if (fault !== 1'b1 || outs !== EXP1) begin
            failures++;
            $display("FAIL fault_enter: fault=%b outs=%h, required 1 and %h", fault, outs, EXP1);
        end
        r0 = req_rises;
        repeat (300) @(posedge sys_clk); #1;
        checks++;
        if (req_rises != r0 || i2c_req !== 1'b0 || fault !== 1'b1 || sv_cnt != sv0 || outs !== EXP1) begin
            failures++;
            $display("FAIL fault_hold: requests=%0d req=%b fault=%b samples=%0d outs=%h, required 0, 0, 1, 0, %h",
                     req_rises - r0, i2c_req, fault, sv_cnt - sv0, outs, EXP1);
        end
    endtask

    initial begin
        test_reset();
        test_sample();
        test_retry();
        test_short_gyro();
        test_overrun();
        test_reset_mid();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
